// File: rtl/mem_pkg.sv
// Shared definitions for the memory port controller.
//   mem_state_t      - FSM state encoding (IDLE / BUSY / DONE)
//   READ_ERR_VALUE   - value returned on ReadData when an access errors
//   DEFAULT_TIMEOUT  - default BUSY cycle budget before an access aborts
//   is_misaligned()  - true when the low byte-address bits are not word aligned
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_BUSY = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_t;

    localparam logic [31:0] READ_ERR_VALUE  = 32'h0;
    localparam int          DEFAULT_TIMEOUT = 16;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter that bounds how long an access may wait for mem_ack.
// Ports:
//   clk     - system clock, rising edge
//   srst    - synchronous active-high reset
//   clear   - returns the count to zero (wins over enable)
//   enable  - count one cycle
//   expired - high while the count equals TIMEOUT-1 (the last allowed cycle)
module timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count_reg;

    assign expired = (count_reg == CW'(TIMEOUT - 1));

    // Saturates at the terminal value so a stalled enable cannot wrap.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Bridges the multicycle controller's single-cycle memory intent onto a
// req/ack handshake with a variable-latency unified memory.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   Adr, WriteData        - byte address and store data from the datapath
//   MemWrite, MemRead     - access intent from the controller
//   ReadData              - registered read result, held between accesses
//   Stall                 - freezes controller FSM and datapath enables
//   BusErr                - sticky misalignment / timeout flag
//   mem_req, mem_we       - memory request and write enable
//   mem_addr, mem_wdata   - word-aligned address and store data to memory
//   mem_rdata, mem_ack    - memory read data and completion pulse
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Adr,
    input  logic [DW-1:0] WriteData,
    input  logic          MemWrite,
    input  logic          MemRead,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic          BusErr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    mem_state_t    state_reg,  state_next;
    logic [DW-1:0] rdata_reg,  rdata_next;
    logic [AW-1:0] addr_reg,   addr_next;
    logic [DW-1:0] wdata_reg,  wdata_next;
    logic          we_reg,     we_next;
    logic          req_reg,    req_next;
    logic          buserr_reg, buserr_next;

    logic start;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    assign start = MemRead | MemWrite;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .srst    (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_next  = state_reg;
        rdata_next  = rdata_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        we_next     = we_reg;
        req_next    = req_reg;
        buserr_next = buserr_reg;
        Stall       = 1'b0;
        cnt_clear   = 1'b1;
        cnt_en      = 1'b0;

        case (state_reg)
            MEM_IDLE: begin
                // Combinational so the controller cannot move past the request cycle.
                Stall = start;
                if (start) begin
                    addr_next  = {Adr[AW-1:2], 2'b00};
                    wdata_next = WriteData;
                    we_next    = MemWrite;  // read+write together resolves to a write
                    if (is_misaligned(Adr[1:0])) begin
                        buserr_next = 1'b1;
                        rdata_next  = DW'(READ_ERR_VALUE);
                        state_next  = MEM_DONE;
                    end else begin
                        if (MemRead && MemWrite) begin
                            buserr_next = 1'b1;
                        end
                        req_next   = 1'b1;
                        state_next = MEM_BUSY;
                    end
                end
            end

            MEM_BUSY: begin
                Stall     = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                // Ack is tested first so an ack on the last allowed cycle still completes.
                if (mem_ack) begin
                    if (!we_reg) begin
                        rdata_next = mem_rdata;
                    end
                    req_next   = 1'b0;
                    state_next = MEM_DONE;
                end else if (cnt_expired) begin
                    req_next    = 1'b0;
                    buserr_next = 1'b1;
                    rdata_next  = DW'(READ_ERR_VALUE);
                    state_next  = MEM_DONE;
                end
            end

            MEM_DONE: begin
                // The controller still holds the finished request here; it is ignored.
                state_next = MEM_IDLE;
            end

            default: begin
                req_next   = 1'b0;
                state_next = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= MEM_IDLE;
            rdata_reg  <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            req_reg    <= 1'b0;
            buserr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rdata_reg  <= rdata_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            we_reg     <= we_next;
            req_reg    <= req_next;
            buserr_reg <= buserr_next;
        end
    end

    assign ReadData  = rdata_reg;
    assign BusErr    = buserr_reg;
    assign mem_req   = req_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: a latency-programmable memory
// responder plus a scoreboard of expected per-access results.
module tb_mem_port_ctrl;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // responder state
    int          resp_lat;
    logic [31:0] resp_data;
    logic        resp_ack;
    logic [31:0] resp_rdata;
    int          busy_cnt;
    logic        late_ack;

    assign mem_ack   = resp_ack | late_ack;
    assign mem_rdata = late_ack ? 32'hDEADBEEF : resp_rdata;

    mem_port_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Adr       (Adr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks in the BUSY cycle numbered resp_lat (0 = first).
    initial begin
        resp_ack   = 1'b0;
        resp_rdata = 32'hBAD0BAD0;
        busy_cnt   = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                resp_ack   = (busy_cnt == resp_lat);
                resp_rdata = resp_ack ? resp_data : 32'hBAD0BAD0;
                busy_cnt++;
            end else begin
                resp_ack   = 1'b0;
                resp_rdata = 32'hBAD0BAD0;
                busy_cnt   = 0;
            end
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        buserr;
        int          stall_n;
        int          req_n;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] model_rdata;
    logic        model_buserr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one access from the cycle after the current negedge and returns
    // at the negedge of the DONE cycle with the request still held.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] adr, input logic [31:0] wd,
                              input logic [31:0] mdata, input int lat);
        exp_t e;
        exp_t got_e;
        int   stall_n;
        int   req_n;
        int   bad;
        int   first_req;
        bit   done_seen;

        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        Adr       = adr;
        WriteData = wd;
        resp_lat  = lat;
        resp_data = mdata;

        if (adr[1:0] != 2'b00) begin
            model_rdata  = 32'h0;
            model_buserr = 1'b1;
            e.stall_n    = 1;
            e.req_n      = 0;
        end else if (lat >= TMO) begin
            model_rdata  = 32'h0;
            model_buserr = 1'b1;
            e.stall_n    = TMO + 1;
            e.req_n      = TMO;
        end else begin
            if (!wr) model_rdata = mdata;
            if (rd && wr) model_buserr = 1'b1;
            e.stall_n = lat + 2;
            e.req_n   = lat + 1;
        end
        e.tag    = tag;
        e.rdata  = model_rdata;
        e.buserr = model_buserr;
        sb.push_back(e);

        #1;
        check_eq({tag, "_req_stall"}, {31'b0, Stall}, 32'd1);
        stall_n   = 1;
        req_n     = 0;
        bad       = 0;
        first_req = -1;
        done_seen = 1'b0;
        for (int it = 1; it <= 64; it++) begin
            @(negedge clk);
            if (mem_req) begin
                req_n++;
                if (first_req < 0) first_req = it;
                if (mem_addr !== {adr[31:2], 2'b00} || mem_we !== wr || mem_wdata !== wd) bad++;
            end
            if (!Stall) begin
                done_seen = 1'b1;
                break;
            end
            stall_n++;
        end
        check_eq({tag, "_done_reached"}, {31'b0, done_seen}, 32'd1);

        got_e = sb.pop_front();
        check_eq({got_e.tag, "_rdata"},  ReadData,         got_e.rdata);
        check_eq({got_e.tag, "_buserr"}, {31'b0, BusErr},  {31'b0, got_e.buserr});
        check_eq({got_e.tag, "_stall_cycles"}, stall_n,    got_e.stall_n);
        check_eq({got_e.tag, "_req_cycles"},   req_n,      got_e.req_n);
        check_eq({got_e.tag, "_req_stable"},   bad,        32'd0);
        if (got_e.req_n > 0) begin
            check_eq({got_e.tag, "_req_start"}, first_req, 32'd1);
        end
        $display("txn %s: adr=%h we=%b stall=%0d req=%0d rdata=%h buserr=%b",
                 tag, adr, wr, stall_n, req_n, ReadData, BusErr);
    endtask

    task automatic go_idle(input string tag);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle_stall"},  {31'b0, Stall},   32'd0);
        check_eq({tag, "_idle_req"},    {31'b0, mem_req}, 32'd0);
        check_eq({tag, "_idle_buserr"}, {31'b0, BusErr},  {31'b0, model_buserr});
        check_eq({tag, "_idle_rdata"},  ReadData,         model_rdata);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        Adr          = 32'h0;
        WriteData    = 32'h0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        resp_lat     = 1000;
        resp_data    = 32'h0;
        late_ack     = 1'b0;
        model_rdata  = 32'h0;
        model_buserr = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_rdata",  ReadData,           32'h0);
        check_eq("rst_stall",  {31'b0, Stall},     32'd0);
        check_eq("rst_buserr", {31'b0, BusErr},    32'd0);
        check_eq("rst_req",    {31'b0, mem_req},   32'd0);
        check_eq("rst_we",     {31'b0, mem_we},    32'd0);
        check_eq("rst_addr",   mem_addr,           32'h0);
        check_eq("rst_wdata",  mem_wdata,          32'h0);
        $display("txn reset: outputs sampled after reset");

        run_access("rd_lat0", 1'b1, 1'b0, 32'h100, 32'h0, 32'hE3A00005, 0);
        go_idle("rd_lat0");

        run_access("wr_lat3", 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 3);
        go_idle("wr_lat3");

        // fetch then load, second request driven in the cycle right after DONE
        run_access("b2b_fetch", 1'b1, 1'b0, 32'h104, 32'h0, 32'hAAAA0001, 0);
        run_access("b2b_load",  1'b1, 1'b0, 32'h200, 32'h0, 32'h55550002, 0);
        go_idle("b2b_load");

        // ack on the last allowed BUSY cycle beats the timeout
        run_access("rd_ack_at_limit", 1'b1, 1'b0, 32'h300, 32'h0, 32'h0F0F1234, TMO - 1);
        go_idle("rd_ack_at_limit");

        run_access("misaligned", 1'b1, 1'b0, 32'h102, 32'h0, 32'h11111111, 0);
        go_idle("misaligned");

        run_access("rd_after_err", 1'b1, 1'b0, 32'h108, 32'h0, 32'h13572468, 1);
        go_idle("rd_after_err");

        run_access("timeout", 1'b1, 1'b0, 32'h10C, 32'h0, 32'h99999999, 1000);
        go_idle("timeout");
        go_idle("timeout_sticky");

        // reset during the second BUSY cycle, then a stray ack in IDLE
        @(negedge clk);
        MemRead   = 1'b1;
        Adr       = 32'h400;
        resp_lat  = 1000;
        @(negedge clk);
        @(negedge clk);
        check_eq("midrst_busy_req", {31'b0, mem_req}, 32'd1);
        reset   = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        reset        = 1'b0;
        model_rdata  = 32'h0;
        model_buserr = 1'b0;
        check_eq("midrst_req",   {31'b0, mem_req}, 32'd0);
        check_eq("midrst_stall", {31'b0, Stall},   32'd0);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        check_eq("late_ack_rdata", ReadData,          32'h0);
        check_eq("late_ack_req",   {31'b0, mem_req},  32'd0);
        check_eq("late_ack_stall", {31'b0, Stall},    32'd0);
        check_eq("late_ack_buserr",{31'b0, BusErr},   32'd0);
        $display("txn midrst: rdata=%h req=%b buserr=%b", ReadData, mem_req, BusErr);

        run_access("rd_and_wr", 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 32'h77777777, 2);
        go_idle("rd_and_wr");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Sits between the multicycle ARM controller/datapath and the unified instruction/data memory.
- Converts the controller's single-cycle memory intent (MemWrite, plus MemRead from the fetch and memory-read states) into a req/ack handshake with a variable-latency memory.
- Drives Stall, which freezes the controller FSM and every datapath enable (PCWrite, IRWrite, RegWrite) until the access completes.
- Detects misaligned accesses and accesses that time out, and reports both through a sticky error flag.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, BUSY cycles without mem_ack before the access aborts (must be ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Adr  in  AW  byte address from the datapath address mux (AdrSrc already applied).
- WriteData  in  DW  store data.
- MemWrite  in  1  write request, gated by the controller's condition logic.
- MemRead  in  1  read request (fetch or load).
- ReadData  out  DW  registered read result; holds its value between accesses.
- Stall  out  1  freeze controller and datapath enables.
- BusErr  out  1  sticky error flag, cleared only by reset.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid while mem_req=1.
- mem_addr  out  AW  word-aligned address ({Adr[AW-1:2],2'b00}).
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completion pulse.

Behaviour:
- Reset values: state=IDLE, ReadData=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, BusErr=0, timeout counter=0. Stall=0 after reset.
- Reset asserted mid-access: forces IDLE on the next edge and drops mem_req. A late mem_ack arriving in IDLE is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = MemRead|MemWrite.
  - Stall = start, combinational, so the controller never advances past the request cycle.
  - On start: latch mem_addr, mem_wdata and mem_we=MemWrite; go to BUSY.
  - If Adr[1:0]≠0: set BusErr and go straight to DONE with ReadData=0; no memory request is issued.
  - MemRead and MemWrite both high: treated as a write (mem_we=1) and BusErr is set.
- BUSY:
  - mem_req=1, Stall=1; mem_addr, mem_we and mem_wdata are held stable.
  - Counter increments every cycle.
  - On mem_ack: if mem_we=0, ReadData<=mem_rdata (writes leave ReadData unchanged); mem_req<=0; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: mem_req<=0, BusErr<=1, ReadData<=0, go to DONE.
  - mem_ack in the same cycle as the timeout: the ack wins and the access completes normally.
- DONE:
  - Stall=0 for exactly one cycle so the controller advances.
  - Requests seen in DONE are the same transaction still held by the controller and are ignored.
  - Always returns to IDLE; counter cleared.
- Latency: a request issued in cycle n with ack arriving k cycles after BUSY entry (k≥0) completes with Stall low in cycle n+k+2. Minimum: request cycle plus BUSY and DONE, i.e. 3 cycles per access.
- mem_ack in IDLE or DONE: ignored.
- Back-to-back accesses: the request following DONE is accepted in IDLE with no bubble beyond the DONE cycle.

Decomposition:
- Shared package `mem_pkg` holds:
  - state encoding MEM_IDLE=2'b00, MEM_BUSY=2'b01, MEM_DONE=2'b10;
  - READ_ERR_VALUE=32'h0;
  - default TIMEOUT.
- One natural sub-module: `timeout_counter` (clear, enable, terminal-count output), parameterised by TIMEOUT. Everything else stays in mem_port_ctrl.

Test Plan:
- Read, 0-cycle latency:
  - Stimulus: MemRead=1, Adr=0x100; memory acks with mem_rdata=0xE3A00005 in the first BUSY cycle.
  - Response: Stall high 2 cycles, then low 1 cycle; ReadData=0xE3A00005; mem_we=0; mem_addr=0x100.
- Write, 3-cycle latency:
  - Stimulus: MemWrite=1, Adr=0x20, WriteData=0x12345678; ack after 3 BUSY cycles.
  - Response: mem_req high exactly 4 cycles with mem_we=1 and mem_wdata=0x12345678 stable; ReadData unchanged; BusErr=0.
- Timeout:
  - Stimulus: TIMEOUT=16, read with no ack.
  - Response: mem_req drops after 16 BUSY cycles; BusErr=1 and remains 1; ReadData=0; Stall releases for one cycle.
- Misaligned access:
  - Stimulus: read with Adr=0x102.
  - Response: mem_req never asserts; BusErr=1; DONE reached the cycle after the request.
- Reset mid-access:
  - Stimulus: assert reset during the 2nd BUSY cycle, then ack one cycle later.
  - Response: mem_req=0 and Stall=0 after the edge; the late ack is ignored; ReadData=0.
- Back-to-back:
  - Stimulus: fetch, then load, each acked immediately.
  - Response: second mem_req asserts 1 cycle after the first DONE; both ReadData values captured in order.
